// File: rtl/vga_frame_scanout.sv
// 640x480@60 VGA scan-out of a 64x48 frame buffer. Each buffer cell covers a
// 10x10 block of screen pixels. Addresses are issued one cycle after the
// counters, the buffer answers one cycle later, and the decoded colour leaves
// together with the equally delayed syncs three cycles after the counters.
module vga_frame_scanout #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned SCALE    = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        blank,
   output logic [11:0] fb_addr,
   output logic        fb_rd_en,
   input  logic [5:0]  fb_data,
   output logic [1:0]  r,
   output logic [1:0]  g,
   output logic [1:0]  b,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        frame_start
);

   localparam logic [9:0] HAct     = 10'(H_ACTIVE);
   localparam logic [9:0] HMax     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] HsStart  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HsEnd    = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VAct     = 10'(V_ACTIVE);
   localparam logic [9:0] VMax     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] VsStart  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VsEnd    = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [3:0] SubMax   = 4'(SCALE - 1);

   // Timing and cell counters
   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic [3:0] x_sub_q, x_sub_d;
   logic [3:0] y_sub_q, y_sub_d;
   logic [5:0] cell_x_q, cell_x_d;
   logic [5:0] cell_y_q, cell_y_d;

   // Stage 1: address issue plus control flags
   logic [11:0] addr_q;
   logic        rd_en_q;
   logic        hs1_q, vs1_q, fs1_q;
   // Stage 2: data returning from the buffer
   logic        act2_q, hs2_q, vs2_q, fs2_q;
   // Stage 3: registered outputs
   logic [5:0]  rgb_q;
   logic        hs3_q, vs3_q, de3_q, fs3_q;

   logic h_last, v_last, h_act, v_act, act;
   logic hs_n, vs_n, at_origin;

   // Next-state for the raster and cell counters, plus stage-1 decodes
   always_comb begin
      h_last    = (h_cnt_q == HMax);
      v_last    = (v_cnt_q == VMax);
      h_act     = (h_cnt_q < HAct);
      v_act     = (v_cnt_q < VAct);
      act       = h_act && v_act;
      hs_n      = !((h_cnt_q >= HsStart) && (h_cnt_q < HsEnd));
      vs_n      = !((v_cnt_q >= VsStart) && (v_cnt_q < VsEnd));
      at_origin = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

      h_cnt_d = h_last ? 10'd0 : h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_last) begin
         v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
      end

      // Horizontal cell position only advances across visible pixels
      x_sub_d  = x_sub_q;
      cell_x_d = cell_x_q;
      if (h_last) begin
         x_sub_d  = 4'd0;
         cell_x_d = 6'd0;
      end else if (h_act) begin
         if (x_sub_q == SubMax) begin
            x_sub_d  = 4'd0;
            cell_x_d = cell_x_q + 6'd1;
         end else begin
            x_sub_d = x_sub_q + 4'd1;
         end
      end

      // Vertical cell position advances at the end of each visible line
      y_sub_d  = y_sub_q;
      cell_y_d = cell_y_q;
      if (h_last) begin
         if (v_last) begin
            y_sub_d  = 4'd0;
            cell_y_d = 6'd0;
         end else if (v_act) begin
            if (y_sub_q == SubMax) begin
               y_sub_d  = 4'd0;
               cell_y_d = cell_y_q + 6'd1;
            end else begin
               y_sub_d = y_sub_q + 4'd1;
            end
         end
      end
   end

   // Counter state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q  <= 10'd0;
         v_cnt_q  <= 10'd0;
         x_sub_q  <= 4'd0;
         y_sub_q  <= 4'd0;
         cell_x_q <= 6'd0;
         cell_y_q <= 6'd0;
      end else begin
         h_cnt_q  <= h_cnt_d;
         v_cnt_q  <= v_cnt_d;
         x_sub_q  <= x_sub_d;
         y_sub_q  <= y_sub_d;
         cell_x_q <= cell_x_d;
         cell_y_q <= cell_y_d;
      end
   end

   // Three-stage pipeline keeping colour and syncs aligned
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= 12'd0;
         rd_en_q <= 1'b0;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         fs1_q   <= 1'b0;
         act2_q  <= 1'b0;
         hs2_q   <= 1'b1;
         vs2_q   <= 1'b1;
         fs2_q   <= 1'b0;
         rgb_q   <= 6'd0;
         hs3_q   <= 1'b1;
         vs3_q   <= 1'b1;
         de3_q   <= 1'b0;
         fs3_q   <= 1'b0;
      end else begin
         addr_q  <= act ? {cell_y_q, cell_x_q} : 12'd0;
         rd_en_q <= act;
         hs1_q   <= hs_n;
         vs1_q   <= vs_n;
         fs1_q   <= at_origin;
         act2_q  <= rd_en_q;
         hs2_q   <= hs1_q;
         vs2_q   <= vs1_q;
         fs2_q   <= fs1_q;
         // fb_data belongs to the address issued one cycle earlier
         rgb_q   <= (act2_q && !blank) ? fb_data : 6'd0;
         hs3_q   <= hs2_q;
         vs3_q   <= vs2_q;
         de3_q   <= act2_q;
         fs3_q   <= fs2_q;
      end
   end

   assign fb_addr     = addr_q;
   assign fb_rd_en    = rd_en_q;
   assign r           = rgb_q[5:4];
   assign g           = rgb_q[3:2];
   assign b           = rgb_q[1:0];
   assign hsync       = hs3_q;
   assign vsync       = vs3_q;
   assign de          = de3_q;
   assign frame_start = fs3_q;

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Directed bench for vga_frame_scanout. A cycle-indexed reference of the
// raster (derived from the number of clocks since reset release) is compared
// every cycle; directed steps cover reset, address boundaries, colour decode,
// blanking, frame/line periods and an asynchronous mid-frame reset.
module tb_vga_frame_scanout;

   localparam int HTot  = 800;
   localparam int VTot  = 525;
   localparam int Frame = HTot * VTot;

   logic        clk;
   logic        rst_n;
   logic        blank;
   logic [11:0] fb_addr;
   logic        fb_rd_en;
   logic [5:0]  fb_data;
   logic [1:0]  r, g, b;
   logic        hsync, vsync, de, frame_start;

   logic        model_const;

   vga_frame_scanout dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .blank       (blank),
      .fb_addr     (fb_addr),
      .fb_rd_en    (fb_rd_en),
      .fb_data     (fb_data),
      .r           (r),
      .g           (g),
      .b           (b),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .frame_start (frame_start)
   );

   // 25 MHz pixel clock
   initial clk = 1'b0;
   always #20 clk = ~clk;

   // Frame buffer model: one-cycle read latency
   always @(posedge clk) fb_data <= model_const ? 6'b110110 : fb_addr[5:0];

   int checks = 0;
   int errors = 0;
   int k;
   logic mc_e0, mc_em1;

   int bad_addr, bad_rden, bad_de, bad_hs, bad_vs, bad_fs, bad_rgb, first_bad_k;
   int hs_low_cnt, vs_low_cnt, fs_cnt, fs_period, last_fs_k;
   int hs_first_fall, hs_space_min, hs_space_max, last_hs_fall, vs_first_low, max_addr;
   logic prev_hs;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic act_of(input int p);
      int h, v;
      h = p % HTot;
      v = (p / HTot) % VTot;
      return (h < 640) && (v < 480);
   endfunction

   function automatic logic [11:0] addr_of(input int p);
      int h, v;
      h = p % HTot;
      v = (p / HTot) % VTot;
      if ((h < 640) && (v < 480)) return 12'((v / 10) * 64 + h / 10);
      return 12'd0;
   endfunction

   task automatic note_bad(inout int cnt);
      if (first_bad_k < 0) first_bad_k = k;
      cnt++;
   endtask

   // One clock after reset release; compares every output to the reference
   task automatic tick();
      logic bl;
      int p, h, v;
      logic e_act, e_hs, e_vs, e_fs;
      logic [5:0] e_rgb, data;
      mc_em1 = mc_e0;
      mc_e0  = model_const;
      bl     = blank;
      @(posedge clk);
      #1;
      k++;
      // address side reflects pixel k-1
      if (fb_rd_en !== act_of(k - 1)) note_bad(bad_rden);
      if (fb_addr !== addr_of(k - 1)) note_bad(bad_addr);
      if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
      // output side reflects pixel k-3
      p = k - 3;
      if (p < 0) begin
         e_act = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_rgb = 6'd0;
      end else begin
         h     = p % HTot;
         v     = (p / HTot) % VTot;
         e_act = act_of(p);
         e_hs  = !((h >= 656) && (h <= 751));
         e_vs  = !((v >= 490) && (v <= 491));
         e_fs  = (h == 0) && (v == 0);
         data  = mc_em1 ? 6'b110110 : addr_of(p)[5:0];
         e_rgb = (e_act && !bl) ? data : 6'd0;
      end
      if (de !== e_act) note_bad(bad_de);
      if (hsync !== e_hs) note_bad(bad_hs);
      if (vsync !== e_vs) note_bad(bad_vs);
      if (frame_start !== e_fs) note_bad(bad_fs);
      if ({r, g, b} !== e_rgb) note_bad(bad_rgb);
      // frame-level statistics over the first output frame
      if (k >= 3 && k <= Frame + 2) begin
         if (hsync === 1'b0) hs_low_cnt++;
         if (vsync === 1'b0) begin
            vs_low_cnt++;
            if (vs_first_low < 0) vs_first_low = k;
         end
         if (prev_hs === 1'b1 && hsync === 1'b0) begin
            if (hs_first_fall < 0) hs_first_fall = k;
            else begin
               if (k - last_hs_fall < hs_space_min) hs_space_min = k - last_hs_fall;
               if (k - last_hs_fall > hs_space_max) hs_space_max = k - last_hs_fall;
            end
            last_hs_fall = k;
         end
      end
      if (frame_start === 1'b1) begin
         fs_cnt++;
         if (last_fs_k >= 0 && fs_period < 0) fs_period = k - last_fs_k;
         last_fs_k = k;
      end
      prev_hs = hsync;
   endtask

   task automatic run_to(input int target);
      while (k < target) tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_hsync"}, 32'(hsync), 32'd1);
      check({tag, "_vsync"}, 32'(vsync), 32'd1);
      check({tag, "_de"}, 32'(de), 32'd0);
      check({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
      check({tag, "_rd_en"}, 32'(fb_rd_en), 32'd0);
      check({tag, "_addr"}, 32'(fb_addr), 32'd0);
      check({tag, "_fs"}, 32'(frame_start), 32'd0);
   endtask

   initial begin
      int lastp, nextp, midp;
      rst_n = 1'b0; blank = 1'b0; model_const = 1'b0;
      k = 0; mc_e0 = 1'b0; mc_em1 = 1'b0;
      bad_addr = 0; bad_rden = 0; bad_de = 0; bad_hs = 0; bad_vs = 0; bad_fs = 0;
      bad_rgb = 0; first_bad_k = -1;
      hs_low_cnt = 0; vs_low_cnt = 0; fs_cnt = 0; fs_period = -1; last_fs_k = -1;
      hs_first_fall = -1; hs_space_min = 1 << 30; hs_space_max = 0; last_hs_fall = 0;
      vs_first_low = -1; max_addr = 0; prev_hs = 1'b1;

      // Reset held for 5 cycles
      repeat (5) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Pipeline fill and first reads of line 0
      run_to(1);
      check("first_addr", 32'(fb_addr), 32'd0);
      check("first_rd_en", 32'(fb_rd_en), 32'd1);
      check("de_edge1", 32'(de), 32'd0);
      run_to(2);
      check("de_edge2", 32'(de), 32'd0);
      run_to(3);
      check("de_edge3", 32'(de), 32'd1);
      check("fs_edge3", 32'(frame_start), 32'd1);
      run_to(10);
      check("addr_pix9", 32'(fb_addr), 32'd0);
      run_to(11);
      check("addr_pix10", 32'(fb_addr), 32'd1);
      run_to(20);
      check("addr_pix19", 32'(fb_addr), 32'd1);
      check("rd_en_pix19", 32'(fb_rd_en), 32'd1);
      run_to(701);
      check("rd_en_pix700", 32'(fb_rd_en), 32'd0);
      check("addr_pix700", 32'(fb_addr), 32'd0);

      // Line 10 pixel 0
      run_to(10 * HTot + 1);
      check("addr_line10", 32'(fb_addr), 32'd64);

      // Constant pixel 6'b110110 on line 20, pixel 100, then blanked
      run_to(20 * HTot + 90);
      model_const = 1'b1;
      run_to(20 * HTot + 103);
      check("rgb_r", 32'(r), 32'd3);
      check("rgb_g", 32'(g), 32'd1);
      check("rgb_b", 32'(b), 32'd2);
      blank = 1'b1;
      run_to(20 * HTot + 104);
      check("blank_rgb", 32'({r, g, b}), 32'd0);
      check("blank_de", 32'(de), 32'd1);
      check("blank_rd_en", 32'(fb_rd_en), 32'd1);
      blank = 1'b0;
      model_const = 1'b0;

      // Last visible pixel of the frame
      lastp = 479 * HTot + 639;
      run_to(lastp + 1);
      check("addr_last", 32'(fb_addr), 32'd3071);
      run_to(lastp + 3);
      check("rgb_last", 32'({r, g, b}), 32'd63);

      // Next frame
      nextp = Frame;
      run_to(nextp + 1);
      check("addr_next_frame", 32'(fb_addr), 32'd0);
      check("rd_en_next_frame", 32'(fb_rd_en), 32'd1);
      run_to(nextp + 3);
      check("fs_next_frame", 32'(frame_start), 32'd1);
      check("fs_count", 32'(fs_cnt), 32'd2);
      check("fs_period", 32'(fs_period), 32'(Frame));
      check("hs_first_fall", 32'(hs_first_fall), 32'd659);
      check("hs_spacing_min", 32'(hs_space_min), 32'd800);
      check("hs_spacing_max", 32'(hs_space_max), 32'd800);
      check("hs_low_total", 32'(hs_low_cnt), 32'(96 * VTot));
      check("vs_first_low", 32'(vs_first_low), 32'(490 * HTot + 3));
      check("vs_low_total", 32'(vs_low_cnt), 32'(2 * HTot));
      check("max_addr", 32'(max_addr), 32'd3071);

      // Asynchronous reset at line 200, pixel 300 of the second frame
      midp = Frame + 200 * HTot + 300;
      run_to(midp + 1);
      check("pre_reset_de", 32'(de), 32'd1);
      check("pre_reset_rd_en", 32'(fb_rd_en), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0; mc_e0 = 1'b0; mc_em1 = 1'b0; prev_hs = 1'b1;
      run_to(1);
      check("restart_addr", 32'(fb_addr), 32'd0);
      check("restart_rd_en", 32'(fb_rd_en), 32'd1);
      run_to(2);
      check("restart_de_edge2", 32'(de), 32'd0);
      run_to(3);
      check("restart_de_edge3", 32'(de), 32'd1);
      check("restart_fs", 32'(frame_start), 32'd1);
      run_to(11 * HTot);
      check("restart_addr_line10", 32'(addr_of(11 * HTot - 1)), 32'(fb_addr));

      // Per-cycle reference comparisons, tallied over the whole run
      if (first_bad_k >= 0) $display("first cycle disagreeing with reference: k=%0d", first_bad_k);
      check("cycle_addr", 32'(bad_addr), 32'd0);
      check("cycle_rd_en", 32'(bad_rden), 32'd0);
      check("cycle_de", 32'(bad_de), 32'd0);
      check("cycle_hsync", 32'(bad_hs), 32'd0);
      check("cycle_vsync", 32'(bad_vs), 32'd0);
      check("cycle_frame_start", 32'(bad_fs), 32'd0);
      check("cycle_rgb", 32'(bad_rgb), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
